// File: rtl/boot_loader_if.sv
// Boot loader bus: UART receive handshake, data-memory debug write port and boot status.
interface boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rdy;
  logic        debug;
  logic [15:0] in_addr;
  logic [15:0] wr_data;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  modport master (
    input  rx_data, rx_rdy,
    output clr_rdy, debug, in_addr, wr_data, cpu_hold, boot_done, boot_err
  );

  modport slave (
    output rx_data, rx_rdy,
    input  clr_rdy, debug, in_addr, wr_data, cpu_hold, boot_done, boot_err
  );
endinterface

// File: rtl/boot_loader.sv
// Length-prefixed byte-stream image loader writing big-endian words into data memory.
// Defining BOOT_CHKSUM_EN adds a trailing 8-bit running-sum check byte.
//
// state    | meaning
// LEN_HI   | wait for high byte of word count
// LEN_LO   | wait for low byte of word count, range-check it
// DAT_HI   | wait for high byte of next word
// DAT_LO   | wait for low byte of next word
// WRITE    | issue one debug write, advance address/count
// CHK      | wait for checksum byte (BOOT_CHKSUM_EN only)
// DONE     | image loaded, CPU released
// ERR      | length or checksum fault, CPU held
module boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 8192
) (
  input logic           clk,
  input logic           rst,
  boot_loader_if.master bus
);

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_WRITE  = 3'd4,
`ifdef BOOT_CHKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  len_hi, len_hi_nxt;
  logic [7:0]  hi, hi_nxt;
  logic [7:0]  lo, lo_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] idx, idx_nxt;
  logic [15:0] addr_nxt;
  logic [15:0] data_nxt;
  logic        take;
  logic        rx_ok;
  logic [15:0] len_word;
  state_t      after_data;
`ifdef BOOT_CHKSUM_EN
  logic [7:0]  sum, sum_nxt;
`endif

  // A byte still flagged in the cycle of its own clr_rdy pulse is stale.
  assign rx_ok    = bus.rx_rdy && !bus.clr_rdy;
  assign len_word = {len_hi, bus.rx_data};

`ifdef BOOT_CHKSUM_EN
  assign after_data = S_CHK;
`else
  assign after_data = S_DONE;
`endif

  always_comb begin
    state_nxt  = state;
    take       = 1'b0;
    len_hi_nxt = len_hi;
    hi_nxt     = hi;
    lo_nxt     = lo;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    addr_nxt   = bus.in_addr;
    data_nxt   = bus.wr_data;
`ifdef BOOT_CHKSUM_EN
    sum_nxt    = sum;
`endif
    case (state)
      S_LEN_HI: begin
        if (rx_ok) begin
          take       = 1'b1;
          len_hi_nxt = bus.rx_data;
          state_nxt  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_ok) begin
          take    = 1'b1;
          cnt_nxt = len_word;
          idx_nxt = 16'd0;
          if (len_word == 16'd0)
            state_nxt = after_data;
          else if ({1'b0, len_word} > MAX_LEN)
            state_nxt = S_ERR;
          else
            state_nxt = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (rx_ok) begin
          take      = 1'b1;
          hi_nxt    = bus.rx_data;
          state_nxt = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (rx_ok) begin
          take      = 1'b1;
          lo_nxt    = bus.rx_data;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_nxt  = BASE_ADDR + idx;
        data_nxt  = {hi, lo};
        idx_nxt   = idx + 16'd1;
        cnt_nxt   = cnt - 16'd1;
        state_nxt = (cnt == 16'd1) ? after_data : S_DAT_HI;
      end
`ifdef BOOT_CHKSUM_EN
      S_CHK: begin
        if (rx_ok) begin
          take      = 1'b1;
          state_nxt = (bus.rx_data == sum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_nxt = state;
    endcase
`ifdef BOOT_CHKSUM_EN
    // The check byte itself is excluded from the running sum.
    if (take && (state != S_CHK))
      sum_nxt = sum + bus.rx_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_LEN_HI;
      len_hi        <= 8'd0;
      hi            <= 8'd0;
      lo            <= 8'd0;
      cnt           <= 16'd0;
      idx           <= 16'd0;
`ifdef BOOT_CHKSUM_EN
      sum           <= 8'd0;
`endif
      bus.clr_rdy   <= 1'b0;
      bus.debug     <= 1'b0;
      bus.in_addr   <= 16'd0;
      bus.wr_data   <= 16'd0;
      bus.cpu_hold  <= 1'b1;
      bus.boot_done <= 1'b0;
      bus.boot_err  <= 1'b0;
    end else begin
      state         <= state_nxt;
      len_hi        <= len_hi_nxt;
      hi            <= hi_nxt;
      lo            <= lo_nxt;
      cnt           <= cnt_nxt;
      idx           <= idx_nxt;
`ifdef BOOT_CHKSUM_EN
      sum           <= sum_nxt;
`endif
      bus.clr_rdy   <= take;
      bus.debug     <= (state == S_WRITE);
      bus.in_addr   <= addr_nxt;
      bus.wr_data   <= data_nxt;
      bus.cpu_hold  <= (state != S_DONE);
      bus.boot_done <= (state == S_DONE) || (state == S_ERR);
      bus.boot_err  <= (state == S_ERR);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: UART byte model feeds streams, a monitor checks every debug write.
module tb_boot_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if bus();
  logic [7:0] rx_data_r = 8'd0;
  logic       rx_rdy_r  = 1'b0;
  assign bus.rx_data = rx_data_r;
  assign bus.rx_rdy  = rx_rdy_r;

  boot_loader dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int         checks   = 0;
  int         failures = 0;
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         gap      = 0;
  int         idle     = 0;
  logic       ack_pend = 1'b0;
  int         ack_cnt  = 0;
  int         cyc      = 0;
  int         last_ack = -100;

`ifdef BOOT_CHKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART model: keeps rx_rdy high until the cycle after clr_rdy, then offers the next byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_pend) begin
        rx_rdy_r = 1'b0;
        ack_pend = 1'b0;
        idle     = gap;
      end
      if (bus.clr_rdy === 1'b1) ack_pend = 1'b1;
      if (!rx_rdy_r && !ack_pend) begin
        if (idle > 0) idle--;
        else if (tx_q.size() > 0) begin
          rx_data_r = tx_q.pop_front();
          rx_rdy_r  = 1'b1;
        end
      end
    end
  end

  // Monitor: every debug pulse must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.debug === 1'b1) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("write_addr", 32'(bus.in_addr), 32'(w.addr));
          check("write_data", 32'(bus.wr_data), 32'(w.data));
        end
      end
      if (bus.clr_rdy === 1'b1) begin
        ack_cnt++;
        check("ack_spacing", 32'((cyc - last_ack) >= 2), 32'd1);
        last_ack = cyc;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_clr_rdy"},   32'(bus.clr_rdy),   32'd0);
    check({tag, "_debug"},     32'(bus.debug),     32'd0);
    check({tag, "_in_addr"},   32'(bus.in_addr),   32'd0);
    check({tag, "_wr_data"},   32'(bus.wr_data),   32'd0);
    check({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd1);
    check({tag, "_boot_done"}, 32'(bus.boot_done), 32'd0);
    check({tag, "_boot_err"},  32'(bus.boot_err),  32'd0);
  endtask

  // Called at a negedge; reset is asserted immediately.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    tx_q.delete();
    rx_rdy_r = 1'b0;
    ack_pend = 1'b0;
    idle     = 0;
    @(negedge clk);
    check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
    ack_cnt = 0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.boot_done === 1'b1) break;
      @(negedge clk);
    end
    check({tag, "_boot_done"}, 32'(bus.boot_done), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic err, input int acks);
    check({tag, "_boot_err"},  32'(bus.boot_err),  32'(err));
    check({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'(err));
    check({tag, "_acks"},      32'(ack_cnt),       32'(acks));
    check({tag, "_pending"},   32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Two words with idle gaps between bytes.
    gap = 3;
    exp_q.push_back('{16'h0000, 16'h1234});
    exp_q.push_back('{16'h0001, 16'hABCD});
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_CHKSUM_EN
    tx_q.push_back(8'hC0);
`endif
    wait_done("basic", 200);
    check_end("basic", 1'b0, 6 + CHK_BYTES);
    do_reset("rst_basic");

    // Empty image.
    gap = 1;
    tx_q = '{8'h00, 8'h00};
`ifdef BOOT_CHKSUM_EN
    tx_q.push_back(8'h00);
`endif
    wait_done("empty", 100);
    check_end("empty", 1'b0, 2 + CHK_BYTES);
    do_reset("rst_empty");

`ifdef BOOT_CHKSUM_EN
    // Bad checksum: word still written, then error.
    gap = 0;
    exp_q.push_back('{16'h0000, 16'h55AA});
    tx_q = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h01};
    wait_done("badchk", 100);
    check_end("badchk", 1'b1, 5);
    do_reset("rst_badchk");
`endif

    // Oversize length; trailing bytes must not be acknowledged.
    gap = 0;
    tx_q = '{8'h20, 8'h01, 8'h11, 8'h22};
    wait_done("toolong", 100);
    repeat (10) @(negedge clk);
    check_end("toolong", 1'b1, 2);
    do_reset("rst_toolong");

    // rx_rdy held continuously; three words.
    gap = 0;
    exp_q.push_back('{16'h0000, 16'h0102});
    exp_q.push_back('{16'h0001, 16'h0304});
    exp_q.push_back('{16'h0002, 16'h0506});
    tx_q = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`ifdef BOOT_CHKSUM_EN
    tx_q.push_back(8'h18);
`endif
    wait_done("stream", 200);
    check_end("stream", 1'b0, 8 + CHK_BYTES);
    do_reset("rst_stream");

    // Reset after three bytes, then restream from the base address.
    gap = 2;
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    for (int i = 0; i < 100; i++) begin
      if (ack_cnt >= 3) break;
      @(negedge clk);
    end
    check("mid_acks", 32'(ack_cnt >= 3), 32'd1);
    do_reset("rst_mid");
    gap = 0;
    exp_q.push_back('{16'h0000, 16'hCAFE});
    exp_q.push_back('{16'h0001, 16'hBEEF});
    tx_q = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBE, 8'hEF};
`ifdef BOOT_CHKSUM_EN
    tx_q.push_back(8'h77);
`endif
    wait_done("reload", 200);
    check_end("reload", 1'b0, 6 + CHK_BYTES);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
